// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data request ports and shared memory bus of the arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          bus_err;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_done, d_rdata, d_done, bus_err, m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_done, d_rdata, d_done, bus_err, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory between fetch and data ports
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arbStateT;

  localparam logic [3:0] starveLimit  = 4'(STARVE_LIMIT);
  localparam logic [7:0] timeoutLimit = 8'(TIMEOUT);

  arbStateT      state, stateNext;
  logic          ownerData, ownerDataNext;
  logic          mReq, mReqNext;
  logic          mWe, mWeNext;
  logic [AW-1:0] mAddr, mAddrNext;
  logic [DW-1:0] mWdata, mWdataNext;
  logic [DW-1:0] iRdata, iRdataNext;
  logic [DW-1:0] dRdata, dRdataNext;
  logic          iDone, iDoneNext;
  logic          dDone, dDoneNext;
  logic          busErr, busErrNext;
  logic [3:0]    starveCnt, starveCntNext;
  logic [7:0]    toCnt, toCntNext;
  logic          grantData;
  logic          timedOut;

  // Data wins unless fetch has waited through STARVE_LIMIT consecutive data grants.
  assign grantData = bus.d_req && !(bus.i_req && (starveCnt >= starveLimit));
  assign timedOut  = (toCnt + 8'd1) == timeoutLimit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ownerData <= 1'b0;
      mReq      <= 1'b0;
      mWe       <= 1'b0;
      mAddr     <= '0;
      mWdata    <= '0;
      iRdata    <= '0;
      dRdata    <= '0;
      iDone     <= 1'b0;
      dDone     <= 1'b0;
      busErr    <= 1'b0;
      starveCnt <= 4'd0;
      toCnt     <= 8'd0;
    end else begin
      state     <= stateNext;
      ownerData <= ownerDataNext;
      mReq      <= mReqNext;
      mWe       <= mWeNext;
      mAddr     <= mAddrNext;
      mWdata    <= mWdataNext;
      iRdata    <= iRdataNext;
      dRdata    <= dRdataNext;
      iDone     <= iDoneNext;
      dDone     <= dDoneNext;
      busErr    <= busErrNext;
      starveCnt <= starveCntNext;
      toCnt     <= toCntNext;
    end
  end

  always_comb begin
    stateNext     = state;
    ownerDataNext = ownerData;
    mReqNext      = mReq;
    mWeNext       = mWe;
    mAddrNext     = mAddr;
    mWdataNext    = mWdata;
    iRdataNext    = iRdata;
    dRdataNext    = dRdata;
    iDoneNext     = 1'b0;
    dDoneNext     = 1'b0;
    busErrNext    = 1'b0;
    starveCntNext = starveCnt;
    toCntNext     = toCnt;

    case (state)
      IDLE: begin
        toCntNext = 8'd0;
        if (grantData) begin
          ownerDataNext = 1'b1;
          mReqNext      = 1'b1;
          mWeNext       = bus.d_we;
          mAddrNext     = bus.d_addr;
          mWdataNext    = bus.d_wdata;
          stateNext     = BUSY;
          if (!bus.i_req)
            starveCntNext = 4'd0;
          else if (starveCnt != 4'hF)
            starveCntNext = starveCnt + 4'd1;
        end else if (bus.i_req) begin
          ownerDataNext = 1'b0;
          mReqNext      = 1'b1;
          mWeNext       = 1'b0;
          mAddrNext     = bus.i_addr;
          mWdataNext    = '0;
          starveCntNext = 4'd0;
          stateNext     = BUSY;
        end
      end
      BUSY: begin
        // An ack on the final allowed cycle still completes cleanly.
        if (bus.m_ack) begin
          mReqNext  = 1'b0;
          stateNext = RESP;
          iDoneNext = !ownerData;
          dDoneNext = ownerData;
          if (!ownerData)
            iRdataNext = bus.m_rdata;
          else if (!mWe)
            dRdataNext = bus.m_rdata;
        end else if (timedOut) begin
          mReqNext   = 1'b0;
          stateNext  = RESP;
          busErrNext = 1'b1;
          iDoneNext  = !ownerData;
          dDoneNext  = ownerData;
          if (ownerData)
            dRdataNext = '0;
          else
            iRdataNext = '0;
        end else begin
          toCntNext = toCnt + 8'd1;
        end
      end
      RESP: begin
        toCntNext = 8'd0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.m_req   = mReq;
  assign bus.m_we    = mWe;
  assign bus.m_addr  = mAddr;
  assign bus.m_wdata = mWdata;
  assign bus.i_rdata = iRdata;
  assign bus.d_rdata = dRdata;
  assign bus.i_done  = iDone;
  assign bus.d_done  = dDone;
  assign bus.bus_err = busErr;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - vector table, corner sequences and random run against a transaction model
module tb_mem_port_arbiter;
  localparam int TO = 8;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    bit          isData;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ackDelay;     // BUSY cycle carrying m_ack, 0 = never
    logic [31:0] rdata;
    bit          expErr;
    logic [31:0] expRdata;
    int          expReqCycles;
  } txnVec;

  txnVec vecs [9];
  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0] mem [16];
  logic [31:0] expDRdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic runTxn(input txnVec v);
    int reqCycles = 0;
    int doneCycle = 0;
    if (v.isData) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = v.addr;
    end
    bus.m_ack = 1'b1;              // must be ignored while not BUSY
    bus.m_rdata = 32'hFFFF_0000;
    for (int c = 1; c <= 40 && doneCycle == 0; c++) begin
      step();
      if (bus.m_req) begin
        reqCycles++;
        check("txn m_addr", bus.m_addr, v.addr);
        check("txn m_we", 32'(bus.m_we), 32'(v.isData && v.we));
        if (v.isData && v.we) check("txn m_wdata", bus.m_wdata, v.wdata);
        bus.m_ack = (reqCycles == v.ackDelay);
        bus.m_rdata = bus.m_ack ? v.rdata : 32'h5A5A_5A5A;
      end else begin
        bus.m_ack = 1'b0;
      end
      if (bus.i_done || bus.d_done) doneCycle = c;
    end
    if (doneCycle == 0) begin
      testsRun++; testsFailed++;
      $display("FAIL txn done: got no done within 40 cycles, expected one");
    end else begin
      check("txn i_done", 32'(bus.i_done), 32'(!v.isData));
      check("txn d_done", 32'(bus.d_done), 32'(v.isData));
      check("txn bus_err", 32'(bus.bus_err), 32'(v.expErr));
      check("txn rdata", v.isData ? bus.d_rdata : bus.i_rdata, v.expRdata);
      check("txn m_req cycles", 32'(reqCycles), 32'(v.expReqCycles));
      check("txn latency", 32'(doneCycle), 32'(v.expReqCycles + 1));
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step();
    check("txn done pulse width", {30'd0, bus.i_done, bus.d_done}, 32'd0);
    check("txn idle m_req", 32'(bus.m_req), 32'd0);
  endtask

  task automatic contention();
    string order = "";
    int dones = 0;
    int doubles = 0;
    int both = 0;
    logic prevMreq = 1'b0;
    logic prevDone = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    for (int c = 0; c < 60 && dones < 10; c++) begin
      step();
      if (bus.m_req && !prevMreq) order = {order, (bus.m_addr == 32'h40) ? "D" : "I"};
      bus.m_ack = bus.m_req;
      bus.m_rdata = 32'(c);
      if (bus.i_done && bus.d_done) both++;
      if ((bus.i_done || bus.d_done) && prevDone) doubles++;
      if (bus.i_done || bus.d_done) dones++;
      prevDone = bus.i_done || bus.d_done;
      prevMreq = bus.m_req;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.m_ack = 1'b0;
    testsRun++;
    if (order != "DDDDIDDDDI") begin
      testsFailed++;
      $display("FAIL grant order: got %s, expected DDDDIDDDDI", order);
    end
    check("contention dones", 32'(dones), 32'd10);
    check("contention double pulses", 32'(doubles), 32'd0);
    check("contention both dones", 32'(both), 32'd0);
    step();
    step();
  endtask

  task automatic randomPhase(input int cycles);
    bit tracking = 1'b0;
    bit curData = 1'b0;
    bit curWe = 1'b0;
    bit expErr;
    logic [31:0] curAddr = '0;
    logic [31:0] curWdata = '0;
    logic [31:0] ackData = '0;
    logic [31:0] expR;
    int memLat = 0;
    int memCnt = 0;
    int starveM = 0;
    int endAge = 1;
    bit grantD;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int n = 0; n < cycles; n++) begin
      step();
      if (!tracking) begin
        check("rnd grant timing", 32'(bus.m_req), 32'(endAge >= 1 && (bus.i_req || bus.d_req)));
        if (bus.m_req) begin
          grantD = bus.d_req && !(bus.i_req && starveM >= SL);
          starveM = (grantD && bus.i_req) ? ((starveM < 15) ? starveM + 1 : 15) : 0;
          tracking = 1'b1;
          curData = grantD;
          curWe = grantD && bus.d_we;
          curAddr = grantD ? bus.d_addr : bus.i_addr;
          curWdata = bus.d_wdata;
          memLat = $urandom_range(1, 10);
          memCnt = 0;
          check("rnd grant m_we", 32'(bus.m_we), 32'(curWe));
          if (curWe) check("rnd grant m_wdata", bus.m_wdata, curWdata);
        end else begin
          endAge++;
          bus.m_ack = ($urandom_range(0, 3) == 0);
          bus.m_rdata = $urandom;
        end
      end
      if (tracking) begin
        if (bus.m_req) begin
          memCnt++;
          check("rnd m_addr", bus.m_addr, curAddr);
          check("rnd no done while busy", {30'd0, bus.i_done, bus.d_done}, 32'd0);
          bus.m_ack = (memCnt == memLat);
          bus.m_rdata = bus.m_ack ? mem[curAddr[5:2]] : $urandom;
          if (bus.m_ack) begin
            ackData = mem[curAddr[5:2]];
            if (curWe) mem[curAddr[5:2]] = curWdata;
          end
        end else begin
          expErr = memLat > TO;
          check("rnd busy length", 32'(memCnt), 32'(expErr ? TO : memLat));
          check("rnd i_done", 32'(bus.i_done), 32'(!curData));
          check("rnd d_done", 32'(bus.d_done), 32'(curData));
          check("rnd bus_err", 32'(bus.bus_err), 32'(expErr));
          if (curData) begin
            expR = expErr ? 32'd0 : (curWe ? expDRdata : ackData);
            check("rnd d_rdata", bus.d_rdata, expR);
            expDRdata = expR;
            bus.d_req = 1'b0;
          end else begin
            expR = expErr ? 32'd0 : ackData;
            check("rnd i_rdata", bus.i_rdata, expR);
            bus.i_req = 1'b0;
          end
          tracking = 1'b0;
          endAge = 0;
          bus.m_ack = ($urandom_range(0, 3) == 0);
          bus.m_rdata = $urandom;
        end
      end else begin
        check("rnd no done while idle", {30'd0, bus.i_done, bus.d_done}, 32'd0);
      end
      if (!bus.i_req && $urandom_range(0, 1) == 1) begin
        bus.i_req = 1'b1;
        bus.i_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!bus.d_req && $urandom_range(0, 1) == 1) begin
        bus.d_req = 1'b1;
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = 32'($urandom_range(0, 15)) << 2;
        bus.d_wdata = $urandom;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.m_ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h10,  32'h0,        1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1};
    vecs[1] = '{1'b1, 1'b1, 32'h20,  32'h12345678, 3, 32'hAAAA5555, 1'b0, 32'hDEADBEEF, 3};
    vecs[2] = '{1'b0, 1'b0, 32'h100, 32'h0,        0, 32'h11111111, 1'b1, 32'h0,        TO};
    vecs[3] = '{1'b0, 1'b0, 32'h104, 32'h0,        2, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 2};
    vecs[4] = '{1'b1, 1'b0, 32'h30,  32'h0,        TO, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, TO};
    vecs[5] = '{1'b0, 1'b0, 32'h108, 32'h0,        TO, 32'h13579BDF, 1'b0, 32'h13579BDF, TO};
    vecs[6] = '{1'b1, 1'b1, 32'h34,  32'h55AA55AA, 0, 32'h22222222, 1'b1, 32'h0,        TO};
    vecs[7] = '{1'b1, 1'b0, 32'h38,  32'h0,        TO + 1, 32'h77777777, 1'b1, 32'h0,   TO};
    vecs[8] = '{1'b1, 1'b0, 32'h50,  32'h0,        2, 32'h600DCAFE, 1'b0, 32'h600DCAFE, 2};

    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ack = 1'b0; bus.m_rdata = '0;
    step();
    step();
    check("reset m_req", 32'(bus.m_req), 32'd0);
    check("reset m_we", 32'(bus.m_we), 32'd0);
    check("reset m_addr", bus.m_addr, 32'd0);
    check("reset m_wdata", bus.m_wdata, 32'd0);
    check("reset dones", {30'd0, bus.i_done, bus.d_done}, 32'd0);
    check("reset bus_err", 32'(bus.bus_err), 32'd0);
    check("reset i_rdata", bus.i_rdata, 32'd0);
    check("reset d_rdata", bus.d_rdata, 32'd0);
    reset = 1'b0;
    step();

    for (int k = 0; k < 8; k++) runTxn(vecs[k]);

    contention();

    // Reset lands on the second BUSY cycle of a load that the memory never acks.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h50; bus.m_ack = 1'b0;
    step();
    check("rst busy1 m_req", 32'(bus.m_req), 32'd1);
    step();
    check("rst busy2 m_req", 32'(bus.m_req), 32'd1);
    reset = 1'b1;
    bus.d_req = 1'b0;
    step();
    reset = 1'b0;
    check("rst m_req dropped", 32'(bus.m_req), 32'd0);
    check("rst no d_done", 32'(bus.d_done), 32'd0);
    check("rst d_rdata", bus.d_rdata, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst stays idle", {30'd0, bus.m_req, bus.d_done}, 32'd0);
    end
    runTxn(vecs[8]);

    expDRdata = vecs[8].expRdata;
    randomPhase(3000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
